grad_descent_engine: RTL and testbench

//  Parametrised fixed-point gradient-descent minimiser. Successor to the fixed-iteration top-level minimiser.

---
 rtl/grad_descent_engine.sv | 180 ++++++++++++++++++
 tb/tb_grad_descent_engine.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grad_descent_engine.sv
`default_nettype none
// ============================================================================
// Module  : grad_descent_engine
// Brief   : Fixed-point gradient-descent minimiser driving an external f/f'
//           evaluator over req/ack and tracking the best (x, f(x)) of a run.
// Revision: 1.0
// ============================================================================
module grad_descent_engine #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 8,
  parameter int VAL_W  = 64,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] x_init,
  input  logic [DATA_W-1:0] lr,
  input  logic [DATA_W-1:0] eps,
  input  logic [ITER_W-1:0] max_iter,
  output logic              f_req,
  output logic [DATA_W-1:0] f_x,
  input  logic              f_ack,
  input  logic [VAL_W-1:0]  f_val,
  input  logic [DATA_W-1:0] f_grad,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [DATA_W-1:0] x_at_min,
  output logic [VAL_W-1:0]  y_min,
  output logic [ITER_W-1:0] iter_used
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [VAL_W-1:0]  V_MAX = {1'b0, {(VAL_W-1){1'b1}}};

  localparam logic [1:0] ST_MAXIT = 2'b00;
  localparam logic [1:0] ST_CONV  = 2'b01;
  localparam logic [1:0] ST_ABORT = 2'b10;
  localparam logic [1:0] ST_OVF   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] x_q, lr_q, eps_q, grad_q;
  logic [ITER_W-1:0] max_iter_q;
  logic [VAL_W-1:0]  val_q;
  logic              abort_q;

  logic signed [PROD_W-1:0] prod, prod_sh;
  logic [PROD_W-DATA_W:0]   prod_top;
  logic [DATA_W-1:0]        step, x_next;
  logic [DATA_W:0]          step_ext, step_mag, diff;
  logic [ITER_W-1:0]        iter_inc;
  logic [1:0]               term_status;
  logic step_sat, x_sat, ovf, converged, last_iter, better, abort_any, term;

  // Update-stage arithmetic: everything is evaluated from the captured sample.
  always_comb begin
    prod     = PROD_W'($signed(grad_q)) * PROD_W'($signed(lr_q));
    prod_sh  = prod >>> FRAC_W;
    prod_top = prod_sh[PROD_W-1:DATA_W-1];
    step_sat = !((&prod_top) || !(|prod_top));
    if (step_sat) begin
      step = prod_sh[PROD_W-1] ? D_MIN : D_MAX;
    end else begin
      step = prod_sh[DATA_W-1:0];
    end
    step_ext  = {step[DATA_W-1], step};
    diff      = {x_q[DATA_W-1], x_q} - step_ext;
    x_sat     = diff[DATA_W] ^ diff[DATA_W-1];
    x_next    = x_sat ? (diff[DATA_W] ? D_MIN : D_MAX) : diff[DATA_W-1:0];
    step_mag  = step_ext[DATA_W] ? (~step_ext + (DATA_W+1)'(1)) : step_ext;
    ovf       = step_sat | x_sat;
    converged = step_mag <= {1'b0, eps_q};
    iter_inc  = iter_used + ITER_W'(1);
    last_iter = (iter_inc == max_iter_q);
    better    = $signed(val_q) < $signed(y_min);
    abort_any = abort_q | abort;
    term      = abort_any | ovf | converged | last_iter;
    if (abort_any) begin
      term_status = ST_ABORT;
    end else if (ovf) begin
      term_status = ST_OVF;
    end else if (converged) begin
      term_status = ST_CONV;
    end else begin
      term_status = ST_MAXIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = (max_iter == '0) ? S_DONE : S_EVAL;
      S_EVAL:   if (f_ack) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = term ? S_DONE : S_EVAL;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign f_req = (state == S_EVAL);
  assign busy  = (state == S_EVAL) || (state == S_UPDATE);
  assign done  = (state == S_DONE);
  assign f_x   = x_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      lr_q       <= '0;
      eps_q      <= '0;
      grad_q     <= '0;
      max_iter_q <= '0;
      val_q      <= '0;
      abort_q    <= 1'b0;
      x_at_min   <= '0;
      y_min      <= V_MAX;
      iter_used  <= '0;
      status     <= ST_MAXIT;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x_q        <= x_init;
            lr_q       <= lr;
            eps_q      <= eps;
            max_iter_q <= max_iter;
            abort_q    <= 1'b0;
            x_at_min   <= x_init;
            y_min      <= V_MAX;
            iter_used  <= '0;
            status     <= ST_MAXIT;
          end
        end
        S_EVAL: begin
          abort_q <= abort_q | abort;
          if (f_ack) begin
            val_q  <= f_val;
            grad_q <= f_grad;
          end
        end
        S_UPDATE: begin
          abort_q   <= abort_any;
          iter_used <= iter_inc;
          if (better) begin
            y_min    <= val_q;
            x_at_min <= x_q;
          end
          // On overflow x stays at the last valid point.
          if (term) begin
            status <= term_status;
          end else begin
            x_q <= x_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_grad_descent_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_grad_descent_engine
// Brief   : Self-checking bench: f(x)=x*x evaluator with programmable latency
//           and a plain-arithmetic reference model of the minimiser.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_grad_descent_engine;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [31:0] x_init, lr, eps;
  logic [7:0]  max_iter;
  logic        f_req;
  logic [31:0] f_x;
  logic        f_ack;
  logic [63:0] f_val;
  logic [31:0] f_grad;
  logic        busy, done;
  logic [1:0]  status;
  logic [31:0] x_at_min;
  logic [63:0] y_min;
  logic [7:0]  iter_used;

  localparam logic [63:0] V_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam longint D_MAX = 64'sh7FFF_FFFF;
  localparam longint D_MIN = -64'sh8000_0000;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  bit grad_fixed = 1'b0;
  int ack_count = 0;
  int drop_err = 0;

  grad_descent_engine #(.DATA_W(32), .FRAC_W(8), .VAL_W(64), .ITER_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .x_init(x_init), .lr(lr), .eps(eps), .max_iter(max_iter),
    .f_req(f_req), .f_x(f_x), .f_ack(f_ack), .f_val(f_val), .f_grad(f_grad),
    .busy(busy), .done(done), .status(status), .x_at_min(x_at_min),
    .y_min(y_min), .iter_used(iter_used)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_val(input logic [31:0] x);
    longint sx;
    sx = longint'($signed(x));
    return sx * sx;
  endfunction

  function automatic logic [31:0] model_grad(input logic [31:0] x);
    if (grad_fixed) return 32'hC000_0000;
    return x << 1;
  endfunction

  // Evaluator: acks `lat` cycles after the request is first seen; also flags any request dropped before its ack.
  initial begin
    int cnt;
    bit prev_req, prev_ack;
    cnt = 0; prev_req = 0; prev_ack = 0;
    f_ack = 1'b0; f_val = '0; f_grad = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        cnt = 0; prev_req = 0; prev_ack = 0; f_ack = 1'b0;
      end else begin
        if (prev_req && !prev_ack && f_req !== 1'b1) drop_err++;
        f_ack = 1'b0;
        prev_ack = 0;
        if (f_req === 1'b1) begin
          if (cnt >= lat) begin
            f_ack = 1'b1; prev_ack = 1; cnt = 0; ack_count++;
            f_val = model_val(f_x);
            f_grad = model_grad(f_x);
          end else begin
            cnt++;
          end
        end else begin
          cnt = 0;
        end
        prev_req = (f_req === 1'b1);
      end
    end
  end

  task automatic ref_run(input logic [31:0] x0, input logic [31:0] lr_i, input logic [31:0] eps_i,
                         input int mi, input int abort_iter, output logic [1:0] st, output int it,
                         output logic [31:0] xmin, output logic [63:0] ymin);
    longint x, fv, g, step, xn, mag, yb;
    bit ovf, fin;
    x = longint'($signed(x0)); yb = V_MAX; xmin = x0; it = 0; st = 2'b00; fin = (mi == 0);
    while (!fin) begin
      fv = x * x;
      g = longint'($signed(model_grad(32'(x))));
      it++;
      if (fv < yb) begin yb = fv; xmin = 32'(x); end
      step = (g * longint'($signed(lr_i))) >>> 8;
      ovf = 0;
      if (step > D_MAX) begin step = D_MAX; ovf = 1; end
      else if (step < D_MIN) begin step = D_MIN; ovf = 1; end
      xn = x - step;
      if (xn > D_MAX || xn < D_MIN) ovf = 1;
      mag = (step < 0) ? -step : step;
      fin = 1;
      if (it == abort_iter) st = 2'b10;
      else if (ovf) st = 2'b11;
      else if (mag <= longint'(eps_i)) st = 2'b01;
      else if (it == mi) st = 2'b00;
      else begin x = xn; fin = 0; end
    end
    ymin = yb;
  endtask

  task automatic run_case(input logic [31:0] xi, input logic [31:0] lri, input logic [31:0] epsi,
                          input int mi, input int latency, input bit gfix, input int abort_iter,
                          input int restart_at, input string name);
    logic [1:0]  e_st;
    int          e_it, cyc;
    logic [31:0] e_x;
    logic [63:0] e_y;
    bit          req_seen, abort_sent;
    lat = latency;
    grad_fixed = gfix;
    ref_run(xi, lri, epsi, mi, abort_iter, e_st, e_it, e_x, e_y);
    @(negedge clk);
    x_init = xi; lr = lri; eps = epsi; max_iter = 8'(mi); start = 1'b1; ack_count = 0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check({name, " busy after start"}, busy, (mi != 0));
    cyc = 0; req_seen = 0; abort_sent = 0;
    while (done !== 1'b1 && cyc < 1000) begin
      if (f_req === 1'b1) req_seen = 1;
      start = (cyc == restart_at);
      if (abort_iter != 0 && !abort_sent && f_req === 1'b1 && f_ack !== 1'b1 &&
          ack_count == abort_iter - 1) begin
        abort = 1'b1; abort_sent = 1;
      end else begin
        abort = 1'b0;
      end
      @(negedge clk); #1;
      cyc++;
    end
    start = 1'b0; abort = 1'b0;
    check({name, " done seen"}, (cyc < 1000), 1'b1);
    check({name, " status"}, status, e_st);
    check({name, " iter_used"}, iter_used, 8'(e_it));
    check({name, " x_at_min"}, x_at_min, e_x);
    check({name, " y_min"}, y_min, e_y);
    check({name, " busy at done"}, busy, 1'b0);
    check({name, " f_req seen"}, req_seen, (mi != 0));
    check({name, " no early req drop"}, drop_err, 0);
    if (abort_iter != 0) check({name, " abort issued"}, abort_sent, (e_it == abort_iter));
    if (mi == 0) check({name, " done latency"}, cyc, 0);
    @(negedge clk); #1;
    check({name, " done one cycle"}, done, 1'b0);
    check({name, " status hold"}, status, e_st);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] xr, lrr, epsr;
    int mi, la, ab;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    x_init = '0; lr = '0; eps = '0; max_iter = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset f_req", f_req, 1'b0);
    check("reset f_x", f_x, 32'h0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset status", status, 2'b00);
    check("reset x_at_min", x_at_min, 32'h0);
    check("reset y_min", y_min, V_MAX);
    check("reset iter_used", iter_used, 8'h0);
    rst_n = 1'b1;

    run_case(32'h0A00, 32'h40, 32'h10, 15, 1, 0, 0, -1, "t1");
    check("t1 status const", status, 2'b01);
    check("t1 iter const", iter_used, 8'd8);
    check("t1 xmin const", x_at_min, 32'h14);
    check("t1 ymin const", y_min, 64'h190);

    run_case(32'h0A00, 32'h40, 32'h0, 3, 0, 0, 0, -1, "t2");
    check("t2 status const", status, 2'b00);
    check("t2 iter const", iter_used, 8'd3);
    check("t2 xmin const", x_at_min, 32'h280);

    run_case(32'h0A00, 32'h40, 32'h10, 15, 5, 0, 3, -1, "t3");
    check("t3 status const", status, 2'b10);
    check("t3 iter const", iter_used, 8'd3);

    run_case(32'h7FFF_FF00, 32'h100, 32'h10, 15, 2, 1, 0, -1, "t4");
    check("t4 status const", status, 2'b11);
    check("t4 iter const", iter_used, 8'd1);
    check("t4 xmin const", x_at_min, 32'h7FFF_FF00);

    run_case(32'h0123, 32'h40, 32'h10, 0, 1, 0, 0, -1, "t5");
    check("t5 status const", status, 2'b00);
    check("t5 iter const", iter_used, 8'd0);

    // Asynchronous reset while a request is outstanding.
    lat = 10; grad_fixed = 0;
    @(negedge clk);
    x_init = 32'h0A00; lr = 32'h40; eps = 32'h10; max_iter = 8'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && f_req !== 1'b1; i++) @(negedge clk);
    check("t6 f_req before reset", f_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6 f_req in reset", f_req, 1'b0);
    check("t6 busy in reset", busy, 1'b0);
    check("t6 y_min in reset", y_min, V_MAX);
    check("t6 iter in reset", iter_used, 8'h0);
    check("t6 done in reset", done, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    run_case(32'h0A00, 32'h40, 32'h10, 15, 2, 0, 0, 3, "t6 restart");

    for (int r = 0; r < 25; r++) begin
      xr   = 32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000;
      lrr  = 32'($urandom_range(0, 32'h1FF));
      epsr = 32'($urandom_range(0, 32'h40));
      mi   = int'($urandom_range(1, 20));
      la   = int'($urandom_range(0, 3));
      ab   = 0;
      if (r % 3 == 0) begin
        ab = int'($urandom_range(1, mi));
        la = int'($urandom_range(1, 3));
      end
      run_case(xr, lrr, epsr, mi, la, 0, ab, -1, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
